// File: rtl/phase_start_seq.sv
// Staggered channel-enable sequencer: raises NCH enables STEP cycles apart,
// holds them in RUN, and drops them in reverse order at the same spacing on stop.
module phase_start_seq #(
    parameter int NCH        = 3,
    parameter int CNT_W      = 9,
    parameter int STEP       = 120,
    parameter bit AUTO_START = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    output logic [NCH-1:0] en,
    output logic           ready,
    output logic           busy
);
    localparam int IDX_W = $clog2(NCH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // idx counts enabled channels, so en is always a thermometer of idx
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             armed_reg, armed_next;
    logic [NCH-1:0]   en_reg, en_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             launch;
    logic             step_done;

    // A stop sampled alongside a start in IDLE cancels the launch
    assign launch    = (start || (AUTO_START && armed_reg)) && !stop;
    assign step_done = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            armed_reg <= 1'b1;
            en_reg    <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            armed_reg <= armed_next;
            en_reg    <= en_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:
                if (launch) state_next = (NCH == 1) ? RUN : RAMP_UP;
            RAMP_UP:
                if (stop)
                    state_next = (idx_reg == IDX_ONE) ? IDLE : RAMP_DOWN;
                else if (step_done && idx_reg == IDX_TOP)
                    state_next = RUN;
            RUN:
                if (stop) state_next = (NCH == 1) ? IDLE : RAMP_DOWN;
            RAMP_DOWN:
                if (step_done && idx_reg == IDX_ONE) state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next   = '0;
        idx_next   = idx_reg;
        armed_next = armed_reg;
        case (state_reg)
            IDLE:
                if (launch) begin
                    idx_next   = IDX_ONE;
                    armed_next = 1'b0;
                end
            RAMP_UP:
                if (stop)
                    idx_next = idx_reg - IDX_ONE;
                else if (step_done)
                    idx_next = idx_reg + IDX_ONE;
                else
                    cnt_next = cnt_reg + CNT_ONE;
            RUN:
                if (stop) idx_next = IDX_TOP;
            RAMP_DOWN:
                if (step_done)
                    idx_next = idx_reg - IDX_ONE;
                else
                    cnt_next = cnt_reg + CNT_ONE;
            default: ;
        endcase
        ready_next = (state_next == RUN);
        busy_next  = (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_therm
        assign en_next[gi] = (idx_next > IDX_W'(gi));
    end

    assign en    = en_reg;
    assign ready = ready_reg;
    assign busy  = busy_reg;
endmodule

// File: tb/tb_phase_start_seq.sv
// Bench for phase_start_seq: three configurations share clk/rst/start/stop and
// are tracked by an elapsed-time channel-count model plus literal checkpoints.
module tb_phase_start_seq;
    logic clk, rst, start, stop;
    logic [2:0] en_a;
    logic [0:0] en_b;
    logic [3:0] en_c;
    logic ready_a, busy_a, ready_b, busy_b, ready_c, busy_c;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // A: NCH=3, STEP=2**CNT_W, auto-start.  B: single channel.  C: STEP=1.
    phase_start_seq #(.NCH(3), .CNT_W(2), .STEP(4), .AUTO_START(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .en(en_a), .ready(ready_a), .busy(busy_a));
    phase_start_seq #(.NCH(1), .CNT_W(3), .STEP(4), .AUTO_START(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .en(en_b), .ready(ready_b), .busy(busy_b));
    phase_start_seq #(.NCH(4), .CNT_W(1), .STEP(1), .AUTO_START(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .en(en_c), .ready(ready_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: n channels on, tl = edge of last change, dir = +1 up / -1 down / 0 still
    typedef struct packed {
        int n;
        int tl;
        int dir;
        bit armed;
    } ms_t;

    ms_t ms [3];
    int  cyc;

    function automatic ms_t mnext(ms_t s, int nch, int step, bit aut, int e, bit st, bit sp);
        ms_t r = s;
        if (s.dir == 0 && s.n == 0) begin
            if ((st || (aut && s.armed)) && !sp) begin
                r.n = 1; r.tl = e; r.armed = 1'b0; r.dir = (nch > 1) ? 1 : 0;
            end
        end else if (s.dir == 0 || (s.dir > 0 && sp)) begin
            if (sp) begin
                r.n = s.n - 1; r.tl = e; r.dir = (r.n > 0) ? -1 : 0;
            end
        end else if (s.dir > 0) begin
            if (e - s.tl == step) begin
                r.n = s.n + 1; r.tl = e;
                if (r.n == nch) r.dir = 0;
            end
        end else begin
            if (e - s.tl == step) begin
                r.n = s.n - 1; r.tl = e;
                if (r.n == 0) r.dir = 0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < 3; i++) ms[i] <= '{n: 0, tl: 0, dir: 0, armed: 1'b1};
        end else begin
            cyc   <= cyc + 1;
            ms[0] <= mnext(ms[0], 3, 4, 1'b1, cyc + 1, start, stop);
            ms[1] <= mnext(ms[1], 1, 4, 1'b0, cyc + 1, start, stop);
            ms[2] <= mnext(ms[2], 4, 1, 1'b0, cyc + 1, start, stop);
        end
    end

    task automatic check(string nm, logic [3:0] got, logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp(string nm, logic [3:0] got_en, logic got_rdy, logic got_bsy,
                       ms_t s, int nch);
        logic [3:0] xen;
        xen = 4'((1 << s.n) - 1);
        check({nm, " en"}, got_en, xen);
        check({nm, " ready"}, {3'b0, got_rdy}, {3'b0, (s.n == nch && s.dir == 0)});
        check({nm, " busy"}, {3'b0, got_bsy}, {3'b0, (s.dir != 0)});
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model a", {1'b0, en_a}, ready_a, busy_a, ms[0], 3);
            cmp("model b", {3'b0, en_b}, ready_b, busy_b, ms[1], 1);
            cmp("model c", en_c, ready_c, busy_c, ms[2], 4);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset en_a", {1'b0, en_a}, 4'b0000);
        check("reset ready_a", {3'b0, ready_a}, 4'b0000);
        check("reset busy_a", {3'b0, busy_a}, 4'b0000);
        check("reset en_c", en_c, 4'b0000);
        chk_on = 1'b1;
        rst = 1'b0;

        // Auto-start: E0 / E4 / E8
        tick(1);
        check("auto E0 en_a", {1'b0, en_a}, 4'b0001);
        check("auto E0 busy_a", {3'b0, busy_a}, 4'b0001);
        check("auto E0 en_b idle", {3'b0, en_b}, 4'b0000);
        tick(4);
        check("auto E4 en_a", {1'b0, en_a}, 4'b0011);
        tick(4);
        check("auto E8 en_a", {1'b0, en_a}, 4'b0111);
        check("auto E8 ready_a", {3'b0, ready_a}, 4'b0001);
        check("auto E8 busy_a", {3'b0, busy_a}, 4'b0000);
        tick(2);

        // Ordered stop at S; start at S+1 is ignored by A, launches B and C
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop S en_a", {1'b0, en_a}, 4'b0011);
        check("stop S ready_a", {3'b0, ready_a}, 4'b0000);
        start = 1'b1; tick(1); start = 1'b0;
        check("S+1 en_a", {1'b0, en_a}, 4'b0011);
        check("S+1 en_b", {3'b0, en_b}, 4'b0001);
        check("S+1 ready_b", {3'b0, ready_b}, 4'b0001);
        check("S+1 busy_b", {3'b0, busy_b}, 4'b0000);
        check("S+1 en_c", en_c, 4'b0001);
        tick(1);
        check("S+2 en_c", en_c, 4'b0011);
        tick(1);
        check("S+3 en_c", en_c, 4'b0111);
        tick(1);
        check("S+4 en_c", en_c, 4'b1111);
        check("S+4 en_a", {1'b0, en_a}, 4'b0001);
        tick(4);
        check("S+8 en_a", {1'b0, en_a}, 4'b0000);
        check("S+8 busy_a", {3'b0, busy_a}, 4'b0000);
        tick(2);

        // Restart by start: same 0/4/8 pattern, then start in RUN is ignored
        start = 1'b1; tick(1); start = 1'b0;
        check("restart T en_a", {1'b0, en_a}, 4'b0001);
        tick(4);
        check("restart T+4 en_a", {1'b0, en_a}, 4'b0011);
        tick(4);
        check("restart T+8 en_a", {1'b0, en_a}, 4'b0111);
        start = 1'b1; tick(1); start = 1'b0;
        check("start in RUN en_a", {1'b0, en_a}, 4'b0111);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop all en_c", en_c, 4'b0111);
        check("stop all en_b", {3'b0, en_b}, 4'b0000);
        tick(8);

        // Stop on the same edge as the scheduled en[1] rise
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        check("T+3 en_a", {1'b0, en_a}, 4'b0001);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop T+4 en_a", {1'b0, en_a}, 4'b0000);
        check("stop T+4 busy_a", {3'b0, busy_a}, 4'b0000);
        tick(5);

        // Stop at T+6 during ramp-up
        start = 1'b1; tick(1); start = 1'b0;
        tick(5);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop T+6 en_a", {1'b0, en_a}, 4'b0001);
        check("stop T+6 busy_a", {3'b0, busy_a}, 4'b0001);
        tick(4);
        check("T+10 en_a", {1'b0, en_a}, 4'b0000);
        check("T+10 busy_a", {3'b0, busy_a}, 4'b0000);
        tick(2);

        // Simultaneous start and stop in IDLE
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        check("start+stop en_a", {1'b0, en_a}, 4'b0000);
        check("start+stop en_b", {3'b0, en_b}, 4'b0000);
        check("start+stop en_c", en_c, 4'b0000);
        tick(2);

        // Asynchronous reset mid ramp-up
        start = 1'b1; tick(1); start = 1'b0;
        tick(4);
        check("pre-rst en_a", {1'b0, en_a}, 4'b0011);
        #1 rst = 1'b1;
        #1;
        check("async rst en_a", {1'b0, en_a}, 4'b0000);
        check("async rst busy_a", {3'b0, busy_a}, 4'b0000);
        check("async rst ready_b", {3'b0, ready_b}, 4'b0000);
        check("async rst en_c", en_c, 4'b0000);
        #1 rst = 1'b0;
        tick(1);
        check("re-auto E0 en_a", {1'b0, en_a}, 4'b0001);
        check("re-auto E0 en_c", en_c, 4'b0000);
        tick(4);
        check("re-auto E4 en_a", {1'b0, en_a}, 4'b0011);
        tick(4);
        check("re-auto E8 en_a", {1'b0, en_a}, 4'b0111);
        check("re-auto E8 ready_a", {3'b0, ready_a}, 4'b0001);
        tick(2);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
